// File: rtl/ext_scan_pkg.sv
// Shared types and constants for the external scan-chain driver.
package ext_scan_pkg;

  localparam int IO_BITS = 8;
  localparam logic [1:0] DRIVER_SEL_EXT = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    SHIFT_IN,
    LATCH,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } state_t;

endpackage

// File: rtl/ext_scan_clkgen.sv
// Scan clock divider: CLK_DIV clk low then CLK_DIV clk high per ext_clk cycle,
// with strobes telling the FSM when to sample and when a new low phase begins.
module ext_scan_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic ext_clk,
  output logic sample,
  output logic phase_start_low
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  // Disabled means parked at the start of a low phase, ready for a clean cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      ext_clk <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      ext_clk <= 1'b0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
      ext_clk <= ~ext_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign sample          = en && !ext_clk && (div_cnt == LAST);
  assign phase_start_low = en &&  ext_clk && (div_cnt == LAST);

endmodule

// File: rtl/ext_scan_driver.sv
// External-side scan initiator: writes one design's input byte into the chain,
// latches it, captures all outputs and shifts the target's output byte back.
module ext_scan_driver
  import ext_scan_pkg::*;
#(
  parameter int         NUM_DESIGNS = 498,
  parameter int         CLK_DIV     = 4,
  parameter logic [1:0] DRIVER_SEL  = DRIVER_SEL_EXT,
  // One spare index code so an out-of-range request is expressible even for
  // power-of-two chain sizes.
  parameter int         IW          = $clog2(NUM_DESIGNS + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [IW-1:0]      design_idx,
  input  logic [IO_BITS-1:0] data_in,
  output logic               busy,
  output logic               done,
  output logic [IO_BITS-1:0] data_out,
  output logic               idx_err,
  input  logic               fw_ready,
  output logic [1:0]         driver_sel,
  output logic               ext_clk,
  output logic               ext_data_in,
  output logic               ext_scan,
  output logic               ext_latch,
  input  logic               ext_data_out
);

  localparam int B  = NUM_DESIGNS * IO_BITS;
  localparam int CW = $clog2(B + 1);
  localparam int PW = $clog2(B);
  localparam int BW = $clog2(IO_BITS);
  localparam int LW = $clog2(2 * CLK_DIV + 1);

  localparam logic [CW-1:0] LAST_BIT  = CW'(B - 1);
  localparam logic [IW-1:0] MAX_IDX   = IW'(NUM_DESIGNS);
  localparam logic [LW-1:0] LATCH_OFF = LW'(CLK_DIV - 1);
  localparam logic [LW-1:0] LATCH_END = LW'(2 * CLK_DIV - 1);

  state_t             state;
  logic [IW-1:0]      idx_q;
  logic [IO_BITS-1:0] data_q;
  logic [IO_BITS-1:0] shadow;
  logic [CW-1:0]      bit_cnt;
  logic [LW-1:0]      lat_cnt;

  logic          clk_en;
  logic          sample;
  logic          phase_start_low;
  logic [PW-1:0] pos_cur;
  logic [PW-1:0] pos_nxt;
  logic          hit_cur;
  logic          hit_nxt;

  assign clk_en = (state == SHIFT_IN) || (state == CAPTURE) || (state == SHIFT_OUT);

  ext_scan_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk             (clk),
    .reset_n         (reset_n),
    .en              (clk_en),
    .ext_clk         (ext_clk),
    .sample          (sample),
    .phase_start_low (phase_start_low)
  );

  // Shift count c maps to chain position B-1-c; its upper bits name the design.
  assign pos_cur = PW'(B - 1) - PW'(bit_cnt);
  assign pos_nxt = pos_cur - PW'(1);
  assign hit_cur = (IW'(pos_cur >> BW) == idx_q);
  assign hit_nxt = (IW'(pos_nxt >> BW) == idx_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx_q       <= '0;
      data_q      <= '0;
      shadow      <= '0;
      bit_cnt     <= '0;
      lat_cnt     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      idx_err     <= 1'b0;
      data_out    <= '0;
      driver_sel  <= 2'b00;
      ext_data_in <= 1'b0;
      ext_scan    <= 1'b0;
      ext_latch   <= 1'b0;
    end else begin
      driver_sel <= DRIVER_SEL;
      done       <= 1'b0;
      idx_err    <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (design_idx < MAX_IDX) begin
              idx_q   <= design_idx;
              data_q  <= data_in;
              bit_cnt <= '0;
              busy    <= 1'b1;
              state   <= WAIT_RDY;
            end else begin
              idx_err <= 1'b1;
            end
          end
        end

        WAIT_RDY: begin
          if (fw_ready) begin
            ext_data_in <= hit_cur && data_q[pos_cur[BW-1:0]];
            state       <= SHIFT_IN;
          end
        end

        // Next bit is presented as each high phase ends, so it settles for a full low phase.
        SHIFT_IN: begin
          if (phase_start_low) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt     <= '0;
              ext_data_in <= 1'b0;
              ext_latch   <= 1'b1;
              lat_cnt     <= '0;
              state       <= LATCH;
            end else begin
              bit_cnt     <= bit_cnt + 1'b1;
              ext_data_in <= hit_nxt && data_q[pos_nxt[BW-1:0]];
            end
          end
        end

        LATCH: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (lat_cnt == LATCH_OFF) begin
            ext_latch <= 1'b0;
          end
          if (lat_cnt == LATCH_END) begin
            ext_scan <= 1'b1;
            state    <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (phase_start_low) begin
            ext_scan <= 1'b0;
            bit_cnt  <= '0;
            state    <= SHIFT_OUT;
          end
        end

        SHIFT_OUT: begin
          if (sample && hit_cur) begin
            shadow[pos_cur[BW-1:0]] <= ext_data_out;
          end
          if (phase_start_low) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt  <= '0;
              data_out <= shadow;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= DONE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
